// File: rtl/mem_arbiter_pkg.sv
// Shared types for the urisc memory arbiter: owner encoding, read-return tag, burst counter helper.
package mem_arbiter_pkg;

  localparam int URISC_AW = 8;
  localparam int URISC_DW = 8;
  localparam int BURST_W  = 4;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] cnt,
                                                  input logic [BURST_W-1:0] max);
    return (cnt >= max) ? max : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter: request/address/data in, grant and read return out.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = URISC_AW,
  parameter int DW = URISC_DW
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// DEPTH-stage shift register of {valid,owner} tags that tracks reads through the memory latency.
// Latency DEPTH cycles; no backpressure, one tag in and one out every cycle; async clear drops all.
module mem_arbiter_rd_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU and DEBUG ports, one access per cycle, bounded bursts.
// Grant is combinational (0 cycles); read data returns MEM_LAT cycles after grant; a low gnt stalls.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW        = URISC_AW,
  parameter int DW        = URISC_DW,
  parameter int MEM_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  cpu_if,
  mem_arbiter_if.slave  dbg_if,
  input  logic          i_dbg_lock,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("mem_arbiter: MEM_LAT must be in 1..4");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("mem_arbiter: MAX_BURST must be in 1..15");
  end

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

  owner_e               r_last_owner;
  logic [BURST_W-1:0]   r_burst_cnt;
  logic [AW-1:0]        r_last_addr;
  logic [DW-1:0]        r_last_wdata;

  logic                 w_cpu_elig;
  logic                 w_dbg_elig;
  logic                 w_cpu_gnt;
  logic                 w_dbg_gnt;
  logic                 w_any_gnt;
  owner_e               w_owner;
  rd_tag_t              w_push_tag;
  rd_tag_t              w_tail_tag;

  // Grants are forced low during reset so the memory sees no access while rst_n is asserted.
  assign w_cpu_elig = i_rst_n & cpu_if.req & ~i_dbg_lock;
  assign w_dbg_elig = i_rst_n & dbg_if.req;

  always_comb begin
    w_owner = OWNER_CPU;
    if (w_cpu_elig && w_dbg_elig) begin
      if (r_burst_cnt < MAX_B) begin
        w_owner = r_last_owner;
      end else if (r_last_owner == OWNER_CPU) begin
        w_owner = OWNER_DBG;
      end else begin
        w_owner = OWNER_CPU;
      end
    end else if (w_dbg_elig) begin
      w_owner = OWNER_DBG;
    end
  end

  assign w_cpu_gnt = w_cpu_elig & (w_owner == OWNER_CPU);
  assign w_dbg_gnt = w_dbg_elig & (w_owner == OWNER_DBG);
  assign w_any_gnt = w_cpu_gnt | w_dbg_gnt;

  assign cpu_if.gnt = w_cpu_gnt;
  assign dbg_if.gnt = w_dbg_gnt;

  always_comb begin
    o_mem_addr  = r_last_addr;
    o_mem_wdata = r_last_wdata;
    o_mem_we    = 1'b0;
    if (w_cpu_gnt) begin
      o_mem_addr  = cpu_if.addr;
      o_mem_wdata = cpu_if.wdata;
      o_mem_we    = cpu_if.we;
    end else if (w_dbg_gnt) begin
      o_mem_addr  = dbg_if.addr;
      o_mem_wdata = dbg_if.wdata;
      o_mem_we    = dbg_if.we;
    end
  end

  // Locked DBG grants leave the fairness state alone so unlocking resumes where it left off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_owner <= OWNER_CPU;
      r_burst_cnt  <= '0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else if (w_any_gnt) begin
      r_last_addr  <= o_mem_addr;
      r_last_wdata <= o_mem_wdata;
      if (!i_dbg_lock) begin
        if (w_owner == r_last_owner) begin
          r_burst_cnt <= burst_inc(r_burst_cnt, MAX_B);
        end else begin
          r_last_owner <= w_owner;
          r_burst_cnt  <= BURST_W'(1);
        end
      end
    end else begin
      r_burst_cnt <= '0;
    end
  end

  assign w_push_tag.valid = w_any_gnt & ~o_mem_we;
  assign w_push_tag.owner = w_owner;

  mem_arbiter_rd_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_rd_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tag   (w_push_tag),
    .o_tag   (w_tail_tag)
  );

  assign cpu_if.rvalid = w_tail_tag.valid & (w_tail_tag.owner == OWNER_CPU);
  assign dbg_if.rvalid = w_tail_tag.valid & (w_tail_tag.owner == OWNER_DBG);
  assign cpu_if.rdata  = i_mem_rdata;
  assign dbg_if.rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=2, MAX_BURST=4) with a two-stage synchronous memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dbg_lock;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_we;

  int tests  = 0;
  int failed = 0;

  mem_arbiter_if cpu_bus ();
  mem_arbiter_if dbg_bus ();

  always #5 clk = ~clk;

  mem_arbiter #(
    .MEM_LAT   (2),
    .MAX_BURST (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .cpu_if      (cpu_bus),
    .dbg_if      (dbg_bus),
    .i_dbg_lock  (dbg_lock),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'hC3;
  endfunction

  // Memory: write and read on the rising edge, one extra output register -> 2-cycle read latency.
  logic [7:0] mem [256];
  logic [7:0] rd1;
  logic [7:0] rd2;
  bit         loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rd1 <= mem[mem_addr];
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    cpu_bus.req   = req;
    cpu_bus.we    = we;
    cpu_bus.addr  = addr;
    cpu_bus.wdata = wd;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    dbg_bus.req   = req;
    dbg_bus.we    = we;
    dbg_bus.addr  = addr;
    dbg_bus.wdata = wd;
  endtask

  initial begin
    rst_n    = 1'b0;
    dbg_lock = 1'b0;
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    drive_dbg(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_gnt", cpu_bus.gnt, 0);
    chk("rst_dbg_gnt", dbg_bus.gnt, 0);
    chk("rst_cpu_rvalid", cpu_bus.rvalid, 0);
    chk("rst_dbg_rvalid", dbg_bus.rvalid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    tick();
    rst_n = 1'b1;

    // 1: CPU-only reads of 0x00..0x07, data back two cycles after each grant
    for (int k = 0; k < 10; k++) begin
      drive_cpu(k < 8, 1'b0, 8'(k), 8'h00);
      @(negedge clk);
      chk("t1_cpu_gnt", cpu_bus.gnt, k < 8);
      chk("t1_dbg_gnt", dbg_bus.gnt, 0);
      if (k < 8) chk("t1_mem_addr", mem_addr, k);
      chk("t1_cpu_rvalid", cpu_bus.rvalid, k >= 2);
      chk("t1_dbg_rvalid", dbg_bus.rvalid, 0);
      if (k >= 2) chk("t1_rdata", cpu_bus.rdata, pat(k - 2));
      tick();
    end

    // 2: both requesting continuously -> CPU x4, DBG x4, CPU x4
    drive_cpu(1'b1, 1'b0, 8'h30, 8'h00);
    drive_dbg(1'b1, 1'b0, 8'h31, 8'h00);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t2_cpu_gnt", cpu_bus.gnt, ((k / 4) % 2) == 0);
      chk("t2_dbg_gnt", dbg_bus.gnt, ((k / 4) % 2) == 1);
      tick();
    end
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    drive_dbg(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) tick();

    // 3: CPU read in flight, then lock with DBG writing 0xA5 to 0x10..0x1F
    drive_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("t3_pre_cpu_gnt", cpu_bus.gnt, 1);
    tick();
    dbg_lock = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_dbg(1'b1, 1'b1, 8'(8'h10 + i), 8'hA5);
      @(negedge clk);
      chk("t3_cpu_gnt", cpu_bus.gnt, 0);
      chk("t3_dbg_gnt", dbg_bus.gnt, 1);
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_addr", mem_addr, 8'h10 + i);
      chk("t3_mem_wdata", mem_wdata, 8'hA5);
      chk("t3_dbg_rvalid", dbg_bus.rvalid, 0);
      chk("t3_cpu_rvalid", cpu_bus.rvalid, i == 1);
      if (i == 1) chk("t3_inflight_rdata", cpu_bus.rdata, pat(8'h10));
      tick();
    end
    dbg_lock = 1'b0;
    drive_dbg(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t3_unlock_cpu_gnt", cpu_bus.gnt, 1);
    chk("t3_unlock_mem_we", mem_we, 0);
    tick();
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t3_wait_rvalid", cpu_bus.rvalid, 0);
    tick();
    @(negedge clk);
    chk("t3_ret_rvalid", cpu_bus.rvalid, 1);
    chk("t3_ret_rdata", cpu_bus.rdata, 8'hA5);
    tick();

    // 4: alternating CPU read 0x20 / DBG read 0x21
    for (int k = 0; k < 8; k++) begin
      drive_cpu((k < 6) && (k % 2 == 0), 1'b0, 8'h20, 8'h00);
      drive_dbg((k < 6) && (k % 2 == 1), 1'b0, 8'h21, 8'h00);
      @(negedge clk);
      chk("t4_cpu_gnt", cpu_bus.gnt, (k < 6) && (k % 2 == 0));
      chk("t4_dbg_gnt", dbg_bus.gnt, (k < 6) && (k % 2 == 1));
      chk("t4_cpu_rvalid", cpu_bus.rvalid, (k >= 2) && (k % 2 == 0));
      chk("t4_dbg_rvalid", dbg_bus.rvalid, (k >= 2) && (k % 2 == 1));
      if (k >= 2) chk("t4_rdata", cpu_bus.rdata, (k % 2 == 0) ? pat(8'h20) : pat(8'h21));
      tick();
    end

    // 6: CPU write 0x3C to 0x40, then read it back
    drive_cpu(1'b1, 1'b1, 8'h40, 8'h3C);
    @(negedge clk);
    chk("t6_cpu_gnt", cpu_bus.gnt, 1);
    chk("t6_mem_we", mem_we, 1);
    chk("t6_mem_addr", mem_addr, 8'h40);
    chk("t6_mem_wdata", mem_wdata, 8'h3C);
    tick();
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_idle_mem_we", mem_we, 0);
      chk("t6_hold_addr", mem_addr, 8'h40);
      chk("t6_hold_wdata", mem_wdata, 8'h3C);
      chk("t6_no_rvalid", cpu_bus.rvalid, 0);
      tick();
    end
    drive_cpu(1'b1, 1'b0, 8'h40, 8'h00);
    @(negedge clk);
    chk("t6_rd_gnt", cpu_bus.gnt, 1);
    tick();
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    @(negedge clk);
    chk("t6_rd_rvalid", cpu_bus.rvalid, 1);
    chk("t6_rd_rdata", cpu_bus.rdata, 8'h3C);
    tick();

    // 5: async reset with a CPU read and a DBG read in flight
    drive_cpu(1'b1, 1'b0, 8'h05, 8'h00);
    @(negedge clk);
    chk("t5_cpu_gnt", cpu_bus.gnt, 1);
    tick();
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    drive_dbg(1'b1, 1'b0, 8'h06, 8'h00);
    @(negedge clk);
    chk("t5_dbg_gnt", dbg_bus.gnt, 1);
    tick();
    drive_cpu(1'b1, 1'b0, 8'h07, 8'h00);
    drive_dbg(1'b1, 1'b0, 8'h08, 8'h00);
    #1;
    chk("t5_pre_cpu_rvalid", cpu_bus.rvalid, 1);
    chk("t5_pre_dbg_gnt", dbg_bus.gnt, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cpu_gnt", cpu_bus.gnt, 0);
    chk("t5_rst_dbg_gnt", dbg_bus.gnt, 0);
    chk("t5_rst_cpu_rvalid", cpu_bus.rvalid, 0);
    chk("t5_rst_mem_we", mem_we, 0);
    chk("t5_rst_mem_addr", mem_addr, 0);
    chk("t5_rst_mem_wdata", mem_wdata, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_post_cpu_gnt", cpu_bus.gnt, 1);
    chk("t5_post_dbg_gnt", dbg_bus.gnt, 0);
    chk("t5_post_cpu_rvalid", cpu_bus.rvalid, 0);
    chk("t5_post_dbg_rvalid", dbg_bus.rvalid, 0);
    tick();
    drive_cpu(1'b0, 1'b0, 8'h00, 8'h00);
    drive_dbg(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t5_drop_cpu_rvalid", cpu_bus.rvalid, 0);
    chk("t5_drop_dbg_rvalid", dbg_bus.rvalid, 0);
    tick();
    @(negedge clk);
    chk("t5_new_rvalid", cpu_bus.rvalid, 1);
    chk("t5_new_rdata", cpu_bus.rdata, pat(8'h07));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
